// File: rtl/carrier_phase_rotator.sv
// Carrier phase rotator: an NCO phase accumulator drives a cos/sin ROM, and each
// incoming I/Q sample is rotated by -theta in a fixed 4-stage pipeline
// (S1 capture, S2 ROM read, S3 multiply, S4 round/saturate).
module carrier_phase_rotator #(
    parameter int NB_DATA_IN  = 8,
    parameter int NB_DATA_OUT = 8,
    parameter int NB_PHASE    = 16,
    parameter int NB_LUT_ADDR = 8,
    parameter int NB_COEF     = 16
) (
    input  logic                          i_clock,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic signed [NB_DATA_IN-1:0]  i_data_i,
    input  logic signed [NB_DATA_IN-1:0]  i_data_q,
    input  logic        [NB_PHASE-1:0]    i_freq_word,
    input  logic        [NB_PHASE-1:0]    i_phase_corr,
    input  logic                          i_clear_phase,
    output logic                          o_valid,
    output logic signed [NB_DATA_OUT-1:0] o_data_i,
    output logic signed [NB_DATA_OUT-1:0] o_data_q
);

    localparam int  NB_PROD    = NB_DATA_IN + NB_COEF;
    localparam int  NB_SUM     = NB_PROD + 1;
    localparam int  LUT_DEPTH  = 1 << NB_LUT_ADDR;
    localparam int  COEF_MAX   = (1 << (NB_COEF - 1)) - 1;
    localparam real PI         = 3.14159265358979323846;
    localparam real COEF_SCALE = 2.0 ** (NB_COEF - 1);

    localparam logic signed [NB_SUM-1:0] ROUND_HALF = NB_SUM'(1 << (NB_COEF - 2));
    localparam logic signed [NB_SUM-1:0] OUT_MAX    = NB_SUM'((1 << (NB_DATA_OUT - 1)) - 1);
    localparam logic signed [NB_SUM-1:0] OUT_MIN    = NB_SUM'(-(1 << (NB_DATA_OUT - 1)));

    // Round to nearest; +1.0 does not fit Q1.(NB_COEF-1) so it clamps to the
    // largest positive code, while -1.0 is representable exactly.
    function automatic int coef_round(input real x);
        int r;
        if (x >= 0.0) begin
            r = $rtoi(x + 0.5);
        end else begin
            r = -$rtoi(0.5 - x);
        end
        if (r > COEF_MAX) begin
            r = COEF_MAX;
        end
        return r;
    endfunction

    // Round half up by adding half an LSB before the arithmetic shift, then clamp.
    function automatic logic signed [NB_DATA_OUT-1:0] round_sat(input logic signed [NB_SUM-1:0] s);
        logic signed [NB_SUM-1:0] r;
        r = (s + ROUND_HALF) >>> (NB_COEF - 1);
        if (r > OUT_MAX) begin
            r = OUT_MAX;
        end else if (r < OUT_MIN) begin
            r = OUT_MIN;
        end
        return NB_DATA_OUT'(r);
    endfunction

    // Full-wave cos/sin ROM, contents fixed at elaboration time.
    logic signed [NB_COEF-1:0] cos_rom [LUT_DEPTH];
    logic signed [NB_COEF-1:0] sin_rom [LUT_DEPTH];

    generate
        for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
            localparam real ANG   = 2.0 * PI * real'(gi) / real'(LUT_DEPTH);
            localparam int  COS_V = coef_round($cos(ANG) * COEF_SCALE);
            localparam int  SIN_V = coef_round($sin(ANG) * COEF_SCALE);
            assign cos_rom[gi] = NB_COEF'(COS_V);
            assign sin_rom[gi] = NB_COEF'(SIN_V);
        end
    endgenerate

    // Phase accumulator state
    logic [NB_PHASE-1:0]    acc_q, acc_d;
    logic [NB_LUT_ADDR-1:0] theta_idx;

    // S1 registers
    logic                         v1_q;
    logic signed [NB_DATA_IN-1:0] s1_i_q, s1_q_q;
    logic [NB_LUT_ADDR-1:0]       s1_k_q;

    // S2 registers
    logic                         v2_q;
    logic signed [NB_DATA_IN-1:0] s2_i_q, s2_q_q;
    logic signed [NB_COEF-1:0]    s2_cos_q, s2_sin_q;

    // S3 registers
    logic                      v3_q;
    logic signed [NB_PROD-1:0] p_icos_q, p_qsin_q, p_qcos_q, p_isin_q;
    logic signed [NB_PROD-1:0] p_icos_d, p_qsin_d, p_qcos_d, p_isin_d;

    // S4 registers
    logic                          v4_q;
    logic signed [NB_DATA_OUT-1:0] out_i_q, out_q_q;
    logic signed [NB_DATA_OUT-1:0] out_i_d, out_q_d;
    logic signed [NB_SUM-1:0]      sum_i, sum_q;

    // Next accumulator value: clear beats advance; advance only on a valid sample.
    always_comb begin
        acc_d     = acc_q;
        theta_idx = acc_q[NB_PHASE-1 -: NB_LUT_ADDR];
        if (i_clear_phase) begin
            acc_d     = '0;
            theta_idx = '0;
        end else if (i_valid) begin
            acc_d = acc_q + i_freq_word + i_phase_corr;
        end
    end

    // Accumulator register
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // S1: capture the sample together with the LUT index of its phase
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            v1_q   <= 1'b0;
            s1_i_q <= '0;
            s1_q_q <= '0;
            s1_k_q <= '0;
        end else begin
            v1_q <= i_valid;
            if (i_valid) begin
                s1_i_q <= i_data_i;
                s1_q_q <= i_data_q;
                s1_k_q <= theta_idx;
            end
        end
    end

    // S2: registered ROM read alongside the delayed sample
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            v2_q     <= 1'b0;
            s2_i_q   <= '0;
            s2_q_q   <= '0;
            s2_cos_q <= '0;
            s2_sin_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_i_q   <= s1_i_q;
                s2_q_q   <= s1_q_q;
                s2_cos_q <= cos_rom[s1_k_q];
                s2_sin_q <= sin_rom[s1_k_q];
            end
        end
    end

    // Full-precision products for the four rotation terms
    always_comb begin
        p_icos_d = NB_PROD'(s2_i_q) * NB_PROD'(s2_cos_q);
        p_qsin_d = NB_PROD'(s2_q_q) * NB_PROD'(s2_sin_q);
        p_qcos_d = NB_PROD'(s2_q_q) * NB_PROD'(s2_cos_q);
        p_isin_d = NB_PROD'(s2_i_q) * NB_PROD'(s2_sin_q);
    end

    // S3: register the products
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            v3_q     <= 1'b0;
            p_icos_q <= '0;
            p_qsin_q <= '0;
            p_qcos_q <= '0;
            p_isin_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                p_icos_q <= p_icos_d;
                p_qsin_q <= p_qsin_d;
                p_qcos_q <= p_qcos_d;
                p_isin_q <= p_isin_d;
            end
        end
    end

    // Rotation by -theta: I' = I cos + Q sin, Q' = Q cos - I sin, then round/saturate
    always_comb begin
        sum_i   = NB_SUM'(p_icos_q) + NB_SUM'(p_qsin_q);
        sum_q   = NB_SUM'(p_qcos_q) - NB_SUM'(p_isin_q);
        out_i_d = round_sat(sum_i);
        out_q_d = round_sat(sum_q);
    end

    // S4: output register, holds its value between valid samples
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            v4_q    <= 1'b0;
            out_i_q <= '0;
            out_q_q <= '0;
        end else begin
            v4_q <= v3_q;
            if (v3_q) begin
                out_i_q <= out_i_d;
                out_q_q <= out_q_d;
            end
        end
    end

    assign o_valid  = v4_q;
    assign o_data_i = out_i_q;
    assign o_data_q = out_q_q;

endmodule

// File: tb/tb_carrier_phase_rotator.sv
// Directed bench for carrier_phase_rotator: a table of single-sample rotations
// at fixed phases, plus sequences for LUT wrap/gaps, reset flush and clear.
module tb_carrier_phase_rotator;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic signed [7:0] di, dq;
    logic [15:0]       freq, corr;
    logic              clr;
    logic              o_valid;
    logic signed [7:0] o_di, o_dq;

    always #5 clk = ~clk;

    carrier_phase_rotator dut (
        .i_clock      (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_data_i     (di),
        .i_data_q     (dq),
        .i_freq_word  (freq),
        .i_phase_corr (corr),
        .i_clear_phase(clr),
        .o_valid      (o_valid),
        .o_data_i     (o_di),
        .o_data_q     (o_dq)
    );

    typedef struct {
        int theta;
        int in_i;
        int in_q;
        int exp_i;
        int exp_q;
    } vec_t;

    vec_t vecs[7];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Expected o_valid: i_valid through four edges, flushed by reset
    logic [3:0] vpipe = '0;
    logic       rst_d = 1'b0;
    logic signed [7:0] last_i = '0, last_q = '0;
    logic signed [7:0] out_i_q[$];
    logic signed [7:0] out_q_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference valid delay line
    always @(posedge clk) begin
        vpipe <= rst ? 4'b0000 : {vpipe[2:0], valid};
        rst_d <= rst;
    end

    // Per-cycle monitor: valid timing, hold behaviour, capture of outputs
    always @(negedge clk) begin
        if (chk_en) begin
            logic signed [7:0] hold_i, hold_q;
            hold_i = rst_d ? 8'sd0 : last_i;
            hold_q = rst_d ? 8'sd0 : last_q;
            total++;
            if (o_valid !== vpipe[3]) begin
                bad++;
                $display("FAIL o_valid_timing t=%0t: got %b expected %b", $time, o_valid, vpipe[3]);
            end
            if (o_valid === 1'b1) begin
                out_i_q.push_back(o_di);
                out_q_q.push_back(o_dq);
                last_i <= o_di;
                last_q <= o_dq;
            end else begin
                chk($sformatf("hold_i t=%0t", $time), int'(o_di), int'(hold_i));
                chk($sformatf("hold_q t=%0t", $time), int'(o_dq), int'(hold_q));
                last_i <= hold_i;
                last_q <= hold_q;
            end
        end
    end

    task automatic send(input bit v, input int a, input int b, input int f, input int c, input bit cl);
        valid = v;
        di    = 8'(a);
        dq    = 8'(b);
        freq  = 16'(f);
        corr  = 16'(c);
        clr   = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic clear_outs();
        out_i_q.delete();
        out_q_q.delete();
    endtask

    task automatic chk_out(input string name, input int idx, input int ei, input int eq);
        if (idx < out_i_q.size()) begin
            $display("%s: out[%0d] = (%0d,%0d) expected (%0d,%0d)", name, idx,
                     int'(out_i_q[idx]), int'(out_q_q[idx]), ei, eq);
            chk({name, "_i"}, int'(out_i_q[idx]), ei);
            chk({name, "_q"}, int'(out_q_q[idx]), eq);
        end else begin
            chk({name, "_present"}, out_i_q.size(), idx + 1);
        end
    endtask

    initial begin
        // theta, I, Q -> expected rotated I, Q
        vecs[0] = '{32'h0000,  100,    0,  100,   0};
        vecs[1] = '{32'h4000,    0,  100,  100,   0};
        vecs[2] = '{32'h8000,   50,  -30,  -50,  30};
        vecs[3] = '{32'h2000, -128, -128, -128,   0};
        vecs[4] = '{32'h0000, -128,  127, -128, 127};
        vecs[5] = '{32'h4000,   10,  -20,  -20, -10};
        vecs[6] = '{32'hC000,   40,    7,   -7,  40};

        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("reset_o_valid", int'(o_valid), 0);
        chk("reset_o_i", int'(o_di), 0);
        chk("reset_o_q", int'(o_dq), 0);
        chk_en = 1'b1;

        // Table: clear acc, a dummy sample sets acc=theta via corr, then the vector sample
        for (int v = 0; v < 7; v++) begin
            clear_outs();
            send(1'b0, 0, 0, 0, 0, 1'b1);
            send(1'b1, 0, 0, 0, vecs[v].theta, 1'b0);
            send(1'b1, vecs[v].in_i, vecs[v].in_q, 0, 0, 1'b0);
            idle(6);
            chk($sformatf("vec%0d_count", v), out_i_q.size(), 2);
            chk_out($sformatf("vec%0d", v), 1, vecs[v].exp_i, vecs[v].exp_q);
        end

        // LUT sweep: index steps by one per sample, wraps at 256, freezes in a 3-cycle gap
        clear_outs();
        send(1'b0, 0, 0, 0, 0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            if (n == 100) idle(3);
            send(1'b1, 100, 0, 16'h0100, 0, 1'b0);
        end
        idle(6);
        chk("sweep_count", out_i_q.size(), 300);
        chk_out("sweep_k0",   0,  100,    0);
        chk_out("sweep_k32",  32,  71,  -71);
        chk_out("sweep_k64",  64,   0, -100);
        chk_out("sweep_k128", 128, -100,  0);
        chk_out("sweep_k160", 160, -71,  71);
        chk_out("sweep_k192", 192,   0, 100);
        chk_out("sweep_wrap", 256, 100,   0);

        // Reset with the pipeline full: nothing in flight may emerge, acc returns to 0
        for (int n = 0; n < 4; n++) send(1'b1, 10, 20, 16'h1000, 0, 1'b0);
        rst = 1'b1;
        send(1'b1, 10, 20, 16'h1000, 16'h0100, 1'b0);
        rst = 1'b0;
        clear_outs();
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("flush_valid%0d", n), int'(o_valid), 0);
            chk($sformatf("flush_i%0d", n), int'(o_di), 0);
            chk($sformatf("flush_q%0d", n), int'(o_dq), 0);
            idle(1);
        end
        chk("flush_no_output", out_i_q.size(), 0);
        send(1'b1, 100, 0, 0, 0, 1'b0);
        idle(6);
        chk_out("post_reset_acc0", 0, 100, 0);

        // Clear together with valid: sample uses theta=0, acc ends at 0 (not the increment)
        clear_outs();
        send(1'b1, 0, 0, 16'h4000, 0, 1'b0);
        send(1'b1, 100, 0, 16'h4000, 0, 1'b1);
        send(1'b1, 100, 0, 16'h4000, 0, 1'b0);
        send(1'b1, 100, 0, 0, 0, 1'b0);
        idle(6);
        chk("clear_count", out_i_q.size(), 4);
        chk_out("clear_same", 1, 100, 0);
        chk_out("clear_next", 2, 100, 0);
        chk_out("clear_after", 3, 0, -100);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
